// File: rtl/topk_sorter_pipe_if.sv
// Handshake bundle for topk_sorter_pipe: batch input channel and result output channel.
// master drives batches and out_ready; slave (the sorter) drives in_ready, out_valid, out_list.
interface topk_sorter_pipe_if #(
    parameter int DIST_W  = 11,
    parameter int LABEL_W = 1,
    parameter int K       = 5,
    parameter int N       = 4
);
    localparam int E = LABEL_W + DIST_W;

    logic             in_valid;
    logic             in_ready;
    logic [N*E-1:0]   in_data;
    logic [N-1:0]     in_mask;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [K*E-1:0]   out_list;

    modport master (
        output in_valid, in_data, in_mask, in_last, out_ready,
        input  in_ready, out_valid, out_list
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_last, out_ready,
        output in_ready, out_valid, out_list
    );
endinterface

// File: rtl/topk_sorter_pipe.sv
// Streaming top-K selector: merges batches of N {label,distance} candidates into a sorted
// list of the K smallest distances, one batch per cycle.
// Ports: clk, rst_n (async, active-low), clear (sync query restart), bus (slave modport:
// in_valid/in_ready/in_data/in_mask/in_last, out_valid/out_ready/out_list).
// Optional macro TOPK_BATCH_CNT_EN adds output batch_cnt[15:0] (accepted batches in query).
module topk_sorter_pipe #(
    parameter int DIST_W  = 11,
    parameter int LABEL_W = 1,
    parameter int K       = 5,
    parameter int N       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
`ifdef TOPK_BATCH_CNT_EN
    output logic [15:0]         batch_cnt,
`endif
    topk_sorter_pipe_if.slave   bus
);
    localparam int E = LABEL_W + DIST_W;
    localparam int M = K + N;
    localparam logic [E-1:0] SENT = {E{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [E-1:0] list_q [K];
    logic [E-1:0] list_d [K];
    logic [E-1:0] merged [K];
    logic [E-1:0] cand   [M];
    logic         cval   [M];
    int           rank   [M];
    logic         accept;

    assign bus.in_ready  = (state_q != DONE) && !clear;
    assign bus.out_valid = (state_q == DONE);
    assign accept        = bus.in_valid && bus.in_ready;

    for (genvar j = 0; j < K; j++) begin : g_out
        assign bus.out_list[j*E +: E] = list_q[j];
    end

    // A batch accepted in IDLE starts a new query, so it merges against
    // sentinels rather than the previous (still visible) result.
    // Candidate order doubles as tie priority: list entries first, then lanes.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            cand[j] = (state_q == IDLE) ? SENT : list_q[j];
            cval[j] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            cand[K+i] = bus.in_data[i*E +: E];
            cval[K+i] = bus.in_mask[i];
        end
        for (int c = 0; c < M; c++) begin
            rank[c] = 0;
            for (int d = 0; d < M; d++) begin
                if (d != c && cval[d] &&
                    ((cand[d][DIST_W-1:0] < cand[c][DIST_W-1:0]) ||
                     (cand[d][DIST_W-1:0] == cand[c][DIST_W-1:0] && d < c)))
                    rank[c] = rank[c] + 1;
            end
        end
        for (int j = 0; j < K; j++) begin
            merged[j] = SENT;
            for (int c = 0; c < M; c++) begin
                if (cval[c] && rank[c] == j)
                    merged[j] = cand[c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        for (int j = 0; j < K; j++)
            list_d[j] = list_q[j];
        if (clear) begin
            state_d = IDLE;
            for (int j = 0; j < K; j++)
                list_d[j] = SENT;
        end else begin
            if (accept) begin
                for (int j = 0; j < K; j++)
                    list_d[j] = merged[j];
            end
            unique case (state_q)
                IDLE: if (accept) state_d = bus.in_last ? DONE : RUN;
                RUN:  if (accept && bus.in_last) state_d = DONE;
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int j = 0; j < K; j++)
                list_q[j] <= SENT;
        end else begin
            state_q <= state_d;
            for (int j = 0; j < K; j++)
                list_q[j] <= list_d[j];
        end
    end

`ifdef TOPK_BATCH_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (state_q == DONE && bus.out_ready))
            cnt_d = '0;
        else if (accept && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign batch_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_topk_sorter_pipe.sv
// Directed table-driven bench for topk_sorter_pipe (K=5, N=4, DIST_W=11, LABEL_W=1).
// Hand sequences cover hold in DONE, clear priority and mid-query reset.
module tb_topk_sorter_pipe;
    localparam logic [11:0] S = 12'hFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    topk_sorter_pipe_if #(.DIST_W(11), .LABEL_W(1), .K(5), .N(4)) bus ();

`ifdef TOPK_BATCH_CNT_EN
    logic [15:0] batch_cnt;
`endif

    topk_sorter_pipe #(.DIST_W(11), .LABEL_W(1), .K(5), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
`ifdef TOPK_BATCH_CNT_EN
        .batch_cnt (batch_cnt),
`endif
        .bus       (bus)
    );

    typedef struct {
        logic [47:0] data;
        logic [3:0]  mask;
        logic        last;
        logic [59:0] exp;
        logic        ev;
        logic        hold;
        logic        ack;
    } vec_t;

    vec_t tv [9];

    function automatic logic [47:0] B4(logic [11:0] a, logic [11:0] b,
                                       logic [11:0] c, logic [11:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [59:0] L5(logic [11:0] a, logic [11:0] b, logic [11:0] c,
                                       logic [11:0] d, logic [11:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(logic [47:0] d, logic [3:0] m, logic l);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mask  = m;
        bus.in_last  = l;
        chk("in_ready_before_send", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
        bus.in_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("ack_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("ack_in_ready", {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        tv[0] = '{B4(7, 3, 9, 1), 4'hF, 1, L5(1, 3, 7, 9, S), 1, 0, 1};
        tv[1] = '{B4(50, 40, 30, 20), 4'hF, 0, L5(20, 30, 40, 50, S), 0, 0, 0};
        tv[2] = '{B4(10, 60, 5, 45), 4'hF, 0, L5(5, 10, 20, 30, 40), 0, 0, 0};
        tv[3] = '{B4(25, 25, 1, 99), 4'hF, 1, L5(1, 5, 10, 20, 25), 1, 1, 1};
        tv[4] = '{B4(10, 0, 0, 0), 4'h1, 0, L5(10, S, S, S, S), 0, 0, 0};
        tv[5] = '{B4(12'h80A, 0, 0, 0), 4'h1, 1, L5(10, 12'h80A, S, S, S), 1, 0, 1};
        tv[6] = '{B4(3, 1, 2, 0), 4'h5, 1, L5(2, 3, S, S, S), 1, 0, 1};
        tv[7] = '{B4(1, 2, 3, 4), 4'h0, 1, L5(S, S, S, S, S), 1, 0, 1};
        tv[8] = '{B4(12'h805, 5, 0, 0), 4'h3, 1, L5(12'h805, 5, S, S, S), 1, 0, 1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mask   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_list", {4'd0, bus.out_list}, {4'd0, L5(S, S, S, S, S)});
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

        for (int v = 0; v < 9; v++) begin
            send(tv[v].data, tv[v].mask, tv[v].last);
            chk($sformatf("vec%0d_list", v), {4'd0, bus.out_list}, {4'd0, tv[v].exp});
            chk($sformatf("vec%0d_out_valid", v), {63'd0, bus.out_valid}, {63'd0, tv[v].ev});
            if (tv[v].hold) begin
                bus.in_valid = 1'b1;
                bus.in_mask  = 4'hF;
                bus.in_data  = B4(0, 0, 0, 0);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
                    chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
                    chk("hold_list", {4'd0, bus.out_list}, {4'd0, tv[v].exp});
                end
                bus.in_valid = 1'b0;
                bus.in_mask  = '0;
            end
            if (tv[v].ack) ack();
        end

        // clear with a batch offered while RUN
        send(B4(5, 6, 7, 8), 4'hF, 0);
        @(negedge clk);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = B4(1, 1, 1, 1);
        bus.in_mask  = 4'hF;
        bus.in_last  = 1'b1;
        #1;
        chk("clear_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        chk("clear_list", {4'd0, bus.out_list}, {4'd0, L5(S, S, S, S, S)});
        chk("clear_out_valid", {63'd0, bus.out_valid}, 64'd0);
        send(B4(40, 30, 20, 10), 4'hF, 1);
        chk("after_clear_list", {4'd0, bus.out_list}, {4'd0, L5(10, 20, 30, 40, S)});

        // clear beats out_ready in DONE
        @(negedge clk);
        clear         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("clear_done_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("clear_done_list", {4'd0, bus.out_list}, {4'd0, L5(S, S, S, S, S)});

        // reset in the middle of a query
        send(B4(4, 4, 4, 4), 4'hF, 0);
`ifdef TOPK_BATCH_CNT_EN
        chk("cnt_pre_reset", {48'd0, batch_cnt}, 64'd1);
`endif
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_list", {4'd0, bus.out_list}, {4'd0, L5(S, S, S, S, S)});
`ifdef TOPK_BATCH_CNT_EN
        chk("midrst_cnt", {48'd0, batch_cnt}, 64'd0);
`endif
        rst_n = 1'b1;
        send(B4(8, 7, 6, 5), 4'hF, 0);
`ifdef TOPK_BATCH_CNT_EN
        chk("cnt1", {48'd0, batch_cnt}, 64'd1);
`endif
        send(B4(1, 1, 1, 1), 4'h1, 0);
`ifdef TOPK_BATCH_CNT_EN
        chk("cnt2", {48'd0, batch_cnt}, 64'd2);
`endif
        send(B4(0, 0, 0, 0), 4'h0, 1);
`ifdef TOPK_BATCH_CNT_EN
        chk("cnt3", {48'd0, batch_cnt}, 64'd3);
`endif
        chk("post_rst_list", {4'd0, bus.out_list}, {4'd0, L5(1, 5, 6, 7, 8)});
        chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd1);
        ack();
`ifdef TOPK_BATCH_CNT_EN
        chk("cnt_after_ack", {48'd0, batch_cnt}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/topk_sorter_pipe.md
TOPK_SORTER_PIPE -- requirements
Module: topk_sorter_pipe

Interface
REQ-001 Parameter DIST_W, default 11, distance field width (compare key).
REQ-002 Parameter LABEL_W, default 1, label/group field width above the distance (not compared).
REQ-003 Parameter K, default 5, number of smallest entries kept, legal range 2..16.
REQ-004 Parameter N, default 4, candidate lanes per batch, legal range 1..8.
REQ-005 Entry width E = LABEL_W+DIST_W; entry = {label, distance}.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 clear  in  1  synchronous restart of a new query.
REQ-009 in_valid  in  1  batch present.
REQ-010 in_ready  out  1  batch accepted when in_valid&in_ready.
REQ-011 in_data  in  N*E  lane i at bits [i*E +: E].
REQ-012 in_mask  in  N  lane i participates when 1; masked lanes are ignored.
REQ-013 in_last  in  1  batch is the final one of the query.
REQ-014 out_valid  out  1  result list final and stable.
REQ-015 out_ready  in  1  consumer takes result.
REQ-016 out_list  out  K*E  entry j at [j*E +: E], ascending distance, j=0 smallest.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on first accepted batch; RUN->DONE when the in_last batch commits; DONE->IDLE on out_valid&out_ready; any state->IDLE on clear.
REQ-018 in_ready = 1 in IDLE and RUN, 0 in DONE and in any cycle with clear=1.
REQ-019 Accepted batch is merged into the K-entry list in one cycle; the list register updates on the next rising edge (latency 1); back-to-back batches every cycle are supported at full throughput.
REQ-020 Merge result = K smallest distances of (current list ∪ unmasked lanes), sorted ascending, labels carried with their distance.
REQ-021 Ties: an existing list entry ranks before an equal new lane; among new lanes, lower index ranks first.
REQ-022 Comparison is unsigned on the DIST_W field only; the label never affects ordering.
REQ-023 Sentinel entry = all ones (E bits); the list is filled with sentinels at reset and on clear.
REQ-024 A batch with in_mask = 0 is accepted and leaves the list unchanged; in_last on it still completes the query.
REQ-025 out_valid = 1 exactly in DONE; out_list is held constant while out_valid=1.
REQ-026 out_list is driven from the list register at all times (intermediate results visible, only qualified by out_valid).
REQ-027 clear together with in_valid: clear wins, the batch is dropped (in_ready=0), list becomes sentinels next edge.
REQ-028 clear together with out_ready in DONE: clear wins; the result is discarded.
REQ-029 Fewer than K real candidates in a query: the remaining tail positions keep the sentinel value.

Reset
REQ-030 While rst_n=0: state IDLE, list all sentinels, in_ready=1 after release, out_valid=0.
REQ-031 Reset asserted mid-query aborts it; no partial result is presented after release.

Configuration
REQ-032 Macro TOPK_BATCH_CNT_EN defined: adds output batch_cnt (16 bits) counting accepted batches of the current query, saturating at 65535, zeroed by reset, clear and DONE->IDLE, held during DONE.
REQ-033 Macro undefined: port batch_cnt and its counter are absent; all other behaviour is identical.

Verification (K=5, N=4, DIST_W=11, LABEL_W=1)
REQ-034 Reset, then one batch {7,3,9,1} mask 1111 last -> next cycle out_valid=1, list distances 1,3,7,9,2047(label 1).
REQ-035 Three batches {50,40,30,20},{10,60,5,45},{25,25,1,99} last -> list 1,5,10,20,25; out_ready=0 holds list and in_ready=0 for 10 cycles.
REQ-036 Tie: list holds 10(label0); batch lane0=10(label1) -> label0 entry precedes label1 entry.
REQ-037 clear asserted with in_valid in RUN -> in_ready=0 that cycle, list all 4095, state IDLE.
REQ-038 Mask 0101 batch {3,1,2,0} last -> list 1,0? no: lanes 0,2 only -> 2,3,2047,2047,2047.
REQ-039 rst_n low mid-query for one cycle -> out_valid=0, list all 4095; with TOPK_BATCH_CNT_EN, batch_cnt=0 and counts 1,2,3 on next accepted batches.
